// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised oversampling UART receiver with valid/ready output
//
// Receives asynchronous serial frames (start, DATA_BITS data LSB first, optional
// parity, STOP_BITS stop bits) and presents each word on a valid/ready handshake.
// The oversample tick is derived from clk by an integer divider that only runs
// while a frame is in progress.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   rx          in   serial line, idle high, asynchronous to clk
//   rx_data     out  received word, valid while rx_valid is high
//   rx_valid    out  word available, held until consumed
//   rx_ready    in   consumer accepts the word on rx_valid && rx_ready
//   parity_err  out  parity mismatch on the held word (0 when PARITY = 0)
//   frame_err   out  a stop bit was sampled low on the held word
//   overrun     out  one-cycle pulse when a completed frame was dropped
//   busy        out  receiver is not idle

module uart_rx_param #(
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int OVERSAMPLE      = 8,
  parameter int CLKS_PER_SAMPLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = 4;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLKS_PER_SAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 2);
  localparam logic          HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic [DW-1:0]        div_cnt;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_err_int;
  logic                 frm_err_int;
  logic                 done;
  logic                 tick;
  logic                 sample;

  // Two-flop synchroniser; idles high so reset does not look like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick   = (state != ST_IDLE) && (div_cnt == DIV_LAST);
  // After the start-bit realignment, the last tick of each bit period is mid-bit.
  assign sample = tick && (tick_cnt == TICK_LAST);
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      div_cnt     <= '0;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      par_err_int <= 1'b0;
      frm_err_int <= 1'b0;
      done        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      done    <= 1'b0;
      overrun <= 1'b0;

      // Divider is held at 0 in IDLE so every frame starts with a full tick period.
      if (state == ST_IDLE || tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end

      if (tick) begin
        tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
      end

      unique case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state       <= ST_START;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            par_err_int <= 1'b0;
            frm_err_int <= 1'b0;
          end
        end

        ST_START: begin
          if (tick && tick_cnt == TICK_MID) begin
            if (rx_s) begin
              state <= ST_IDLE;
            end else begin
              state    <= ST_DATA;
              tick_cnt <= '0;
            end
          end
        end

        ST_DATA: begin
          if (sample) begin
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= HAS_PAR ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end

        ST_PARITY: begin
          if (sample) begin
            // XOR over data and parity bit is 0 for good even parity, 1 for good odd.
            par_err_int <= (^shift_reg) ^ rx_s ^ ODD;
            state       <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (sample) begin
            frm_err_int <= frm_err_int | ~rx_s;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              done    <= 1'b1;
              // A low stop bit may be a held-low line; wait for it to go high first.
              state   <= (frm_err_int || !rx_s) ? ST_BREAK : ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end

        ST_BREAK: begin
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase

      // Output handshake; a completion in the consume cycle overrides the clear.
      if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end

      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shift_reg;
          rx_valid   <= 1'b1;
          parity_err <= par_err_int;
          frame_err  <= frm_err_int;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - self-checking bench for uart_rx_param (8N1 and 7E2 instances)

module tb_uart_rx_param;

  localparam int OS_A  = 8;
  localparam int CPS_A = 1;
  localparam int BIT_A = OS_A * CPS_A;
  localparam int OS_B  = 8;
  localparam int CPS_B = 4;
  localparam int BIT_B = OS_B * CPS_B;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       rx_a, rx_b;
  logic [7:0] rx_data_a;
  logic [6:0] rx_data_b;
  logic       rx_valid_a, rx_valid_b;
  logic       rx_ready_a, rx_ready_b;
  logic       parity_err_a, parity_err_b;
  logic       frame_err_a, frame_err_b;
  logic       overrun_a, overrun_b;
  logic       busy_a, busy_b;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  int   hi_a = 0;
  int   ovr_a = 0;
  int   ovr_b = 0;
  int   rise_cyc_a = 0;
  logic prev_valid_a = 1'b0;

  uart_rx_param #(
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(OS_A), .CLKS_PER_SAMPLE(CPS_A)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .rx_ready(rx_ready_a), .parity_err(parity_err_a), .frame_err(frame_err_a),
    .overrun(overrun_a), .busy(busy_a)
  );

  uart_rx_param #(
    .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .OVERSAMPLE(OS_B), .CLKS_PER_SAMPLE(CPS_B)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .rx_ready(rx_ready_b), .parity_err(parity_err_b), .frame_err(frame_err_b),
    .overrun(overrun_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboards: every accepted word must match the head of the expected queue.
  always @(negedge clk) begin
    if (rx_valid_a && !prev_valid_a) rise_cyc_a = cyc;
    prev_valid_a = rx_valid_a;
    if (rx_valid_a) hi_a++;
    if (overrun_a) ovr_a++;
    if (overrun_b) ovr_b++;
    if (rst_n && rx_valid_a && rx_ready_a) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_word", 32'(rx_data_a), 32'hdead);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        check("a_data", 32'(rx_data_a), 32'(e.data));
        check("a_parity_err", 32'(parity_err_a), 32'(e.perr));
        check("a_frame_err", 32'(frame_err_a), 32'(e.ferr));
      end
    end
    if (rst_n && rx_valid_b && rx_ready_b) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_word", 32'(rx_data_b), 32'hdead);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        check("b_data", 32'(rx_data_b), 32'(e.data));
        check("b_parity_err", 32'(parity_err_b), 32'(e.perr));
        check("b_frame_err", 32'(frame_err_b), 32'(e.ferr));
      end
    end
  end

  // Drives nbits line bits LSB first, each held cpb clocks; call just after a rising edge.
  task automatic send_bits(input bit to_b, input logic [15:0] bits, input int nbits, input int cpb);
    for (int i = 0; i < nbits; i++) begin
      if (to_b) rx_b = bits[i];
      else      rx_a = bits[i];
      repeat (cpb) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_a(input logic [7:0] d, input logic stop, input logic ferr_exp, input bit expect_word);
    exp_t e;
    e.data = {1'b0, d};
    e.perr = 1'b0;
    e.ferr = ferr_exp;
    if (expect_word) q_a.push_back(e);
    send_bits(1'b0, {6'b0, stop, d, 1'b0}, 10, BIT_A);
  endtask

  // Even parity: a frame is in error when the total count of ones is odd.
  task automatic send_b(input logic [6:0] d, input logic flip);
    exp_t e;
    logic p;
    p = ($countones(d) % 2 == 1) ^ flip;
    e.data = {2'b0, d};
    e.perr = (($countones(d) + int'(p)) % 2) == 1;
    e.ferr = 1'b0;
    q_b.push_back(e);
    send_bits(1'b1, {5'b0, 2'b11, p, d, 1'b0}, 11, BIT_B);
  endtask

  initial begin
    int k;
    int h0;
    int o0;
    bit seen_idle;
    rst_n = 1'b0;
    rx_a = 1'b1;
    rx_b = 1'b1;
    rx_ready_a = 1'b1;
    rx_ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_a", {rx_data_a, rx_valid_a, parity_err_a, frame_err_a, overrun_a, busy_a}, 0);
    check("reset_outputs_b", {rx_data_b, rx_valid_b, parity_err_b, frame_err_b, overrun_b, busy_b}, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Single 0xA5: rise time = 2 sync + 1 detect + half start bit + 9 bits + 1 completion.
    k = cyc;
    h0 = hi_a;
    send_a(8'hA5, 1'b1, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("a5_latency", rise_cyc_a - k, 2 + 1 + BIT_A / 2 + 9 * BIT_A + 1);
    check("a5_pulse_len", hi_a - h0, 1);
    check("a5_consumed", q_a.size(), 0);

    // Back-to-back stream 0x00..0xFF step 3, then random bytes.
    o0 = ovr_a;
    for (int v = 0; v <= 255; v += 3) send_a(8'(v), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) send_a(8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("stream_all_received", q_a.size(), 0);
    check("stream_no_overrun", ovr_a - o0, 0);

    // Stop bit low, line held low three bit times.
    h0 = hi_a;
    send_a(8'hC3, 1'b0, 1'b1, 1'b1);
    repeat (3 * BIT_A) @(posedge clk);
    #1;
    check("break_busy_held", busy_a, 1);
    rx_a = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("break_busy_released", busy_a, 0);
    repeat (120) @(posedge clk);
    #1;
    check("break_single_word", hi_a - h0, 1);
    check("break_consumed", q_a.size(), 0);

    // 3-clk glitch is rejected.
    h0 = hi_a;
    rx_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_a = 1'b1;
    @(posedge clk);
    #1;
    check("glitch_busy_entered", busy_a, 1);
    seen_idle = 1'b0;
    for (int i = 0; i < OS_A / 2 + 1 && !seen_idle; i++) begin
      @(posedge clk);
      #1;
      if (!busy_a) seen_idle = 1'b1;
    end
    check("glitch_busy_released", seen_idle, 1);
    repeat (120) @(posedge clk);
    #1;
    check("glitch_no_word", hi_a - h0, 0);

    // Overrun: 0x22 completes while 0x11 is still held.
    o0 = ovr_a;
    rx_ready_a = 1'b0;
    send_a(8'h11, 1'b1, 1'b0, 1'b1);
    send_a(8'h22, 1'b1, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("ovr_valid_held", rx_valid_a, 1);
    check("ovr_data_held", rx_data_a, 8'h11);
    check("ovr_one_pulse", ovr_a - o0, 1);
    rx_ready_a = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_valid_cleared", rx_valid_a, 0);
    check("ovr_consumed", q_a.size(), 0);

    // Reset in the middle of a frame while a word is held.
    rx_ready_a = 1'b0;
    send_a(8'h33, 1'b1, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rx_a = 1'b0;
    repeat (3 * BIT_A) @(posedge clk);
    #1;
    check("pre_reset_busy_valid", {busy_a, rx_valid_a}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs",
          {rx_data_a, rx_valid_a, parity_err_a, frame_err_a, overrun_a, busy_a}, 0);
    q_a.delete();
    rx_a = 1'b1;
    rx_ready_a = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    h0 = hi_a;
    repeat (150) @(posedge clk);
    #1;
    check("post_reset_quiet", hi_a - h0, 0);
    send_a(8'h5A, 1'b1, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("post_reset_recovered", q_a.size(), 0);

    // 7E2 instance: correct and flipped parity on 0x55, then random words.
    o0 = ovr_b;
    send_b(7'h55, 1'b0);
    send_b(7'h55, 1'b1);
    for (int i = 0; i < 12; i++) send_b(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
    repeat (6) @(posedge clk);
    #1;
    check("b_all_received", q_b.size(), 0);
    check("b_no_overrun", ovr_b - o0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
